// File: rtl/sprite_line_eval_if.sv
// Bus bundle between the sprite line evaluator and its neighbours:
// control handshake, OAM and graphics read ports, per-slot results.
interface sprite_line_eval_if #(
   parameter int N_OAM       = 64,
   parameter int MAX_SPRITES = 8
);
   localparam int AW = $clog2(N_OAM);

   logic                       start;
   logic [8:0]                 next_line;
   logic                       busy;
   logic                       done;
   logic [AW-1:0]              oam_addr;
   logic [31:0]                oam_rdata;
   logic [8:0]                 gfx_addr;
   logic [31:0]                gfx_rdata;
   logic [MAX_SPRITES-1:0]     sprite_valid;
   logic [MAX_SPRITES*10-1:0]  sprite_x;
   logic [MAX_SPRITES*3-1:0]   sprite_palette;
   logic [MAX_SPRITES*32-1:0]  sprite_pattern;
   logic                       sprite_overflow;

   modport master (
      output start, next_line, oam_rdata, gfx_rdata,
      input  busy, done, oam_addr, gfx_addr,
      input  sprite_valid, sprite_x, sprite_palette,
      input  sprite_pattern, sprite_overflow
   );

   modport slave (
      input  start, next_line, oam_rdata, gfx_rdata,
      output busy, done, oam_addr, gfx_addr,
      output sprite_valid, sprite_x, sprite_palette,
      output sprite_pattern, sprite_overflow
   );
endinterface

// File: rtl/sprite_line_eval.sv
// Scans OAM for sprites on the next scanline, keeps the first
// MAX_SPRITES hits, then fetches each hit's pattern row.
module sprite_line_eval #(
   parameter int N_OAM       = 64,
   parameter int MAX_SPRITES = 8,
   parameter int SPRITE_H    = 8
) (
   input logic               clk,
   input logic               reset,
   sprite_line_eval_if.slave bus
);
   localparam int AW = $clog2(N_OAM);
   localparam int CW = $clog2(MAX_SPRITES + 1);
   localparam int KW = $clog2(MAX_SPRITES);

   typedef enum logic [2:0] {
      IDLE, SCAN, FETCH_REQ, FETCH_WAIT, DONE
   } state_t;

   state_t         state_q, state_d;
   logic [8:0]     line_q;
   logic [AW-1:0]  addr_q;
   logic [AW-1:0]  eidx_q;
   logic           pv_q;
   logic [CW-1:0]  cnt_q;
   logic [KW-1:0]  k_q;
   logic           ovf_q;

   logic [MAX_SPRITES-1:0] valid_q;
   logic [9:0]     x_q    [MAX_SPRITES];
   logic [2:0]     pal_q  [MAX_SPRITES];
   logic [5:0]     tile_q [MAX_SPRITES];
   logic [2:0]     row_q  [MAX_SPRITES];
   logic           hfl_q  [MAX_SPRITES];
   logic [31:0]    pat_q  [MAX_SPRITES];

   logic [9:0]     diff;
   logic           eval, hit, full, take, ovf_hit, last;
   logic [2:0]     row;
   logic [31:0]    rev;
   logic           unused_ok;

   assign unused_ok = &{1'b0, bus.oam_rdata[31:30]};

   // Hit test of the OAM word returned for the entry under evaluation.
   always_comb begin
      diff    = {1'b0, line_q} - {1'b0, bus.oam_rdata[18:10]};
      eval    = (state_q == SCAN) && pv_q;
      hit     = eval && !diff[9] && (diff < 10'(SPRITE_H));
      full    = (cnt_q == CW'(MAX_SPRITES));
      take    = hit && !full;
      ovf_hit = hit && full;
      last    = eval && (eidx_q == AW'(N_OAM - 1));
      row     = bus.oam_rdata[29] ? 3'(SPRITE_H - 1) - diff[2:0]
                                  : diff[2:0];
   end

   // Horizontal flip: pixel i swaps with pixel 7-i.
   always_comb begin
      rev = '0;
      for (int i = 0; i < 8; i++)
         rev[4*i +: 4] = bus.gfx_rdata[4*(7-i) +: 4];
   end

   // Next-state logic for scan and fetch sequencing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:       if (bus.start) state_d = SCAN;
         SCAN: begin
            if (ovf_hit)
               state_d = FETCH_REQ;
            else if (last)
               state_d = (cnt_q == '0 && !take) ? DONE : FETCH_REQ;
         end
         FETCH_REQ:  state_d = FETCH_WAIT;
         FETCH_WAIT: state_d = (CW'(k_q) + CW'(1) == cnt_q) ? DONE
                                                              : FETCH_REQ;
         DONE:       state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Control registers: state, OAM address, eval pipeline, counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         line_q  <= '0;
         addr_q  <= '0;
         eidx_q  <= '0;
         pv_q    <= 1'b0;
         cnt_q   <= '0;
         k_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pv_q    <= (state_q == SCAN) && (state_d == SCAN);
         if (state_q == IDLE && bus.start) begin
            line_q <= bus.next_line;
            addr_q <= '0;
            eidx_q <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
            ovf_q  <= 1'b0;
         end
         if (state_q == SCAN && addr_q != AW'(N_OAM - 1))
            addr_q <= addr_q + AW'(1);
         if (eval)       eidx_q <= eidx_q + AW'(1);
         if (take)       cnt_q  <= cnt_q + CW'(1);
         if (ovf_hit)    ovf_q  <= 1'b1;
         if (state_q == FETCH_WAIT) k_q <= k_q + KW'(1);
      end
   end

   // Slot storage: written on hits during scan, patterns during fetch.
   always_ff @(posedge clk) begin
      if (!reset || (state_q == IDLE && bus.start)) begin
         valid_q <= '0;
         for (int k = 0; k < MAX_SPRITES; k++) begin
            x_q[k]    <= '0;
            pal_q[k]  <= '0;
            tile_q[k] <= '0;
            row_q[k]  <= '0;
            hfl_q[k]  <= 1'b0;
            pat_q[k]  <= '0;
         end
      end else begin
         if (take) begin
            x_q[cnt_q[KW-1:0]]    <= bus.oam_rdata[9:0];
            pal_q[cnt_q[KW-1:0]]  <= bus.oam_rdata[27:25];
            tile_q[cnt_q[KW-1:0]] <= bus.oam_rdata[24:19];
            row_q[cnt_q[KW-1:0]]  <= row;
            hfl_q[cnt_q[KW-1:0]]  <= bus.oam_rdata[28];
         end
         if (state_q == FETCH_WAIT) begin
            pat_q[k_q]   <= hfl_q[k_q] ? rev : bus.gfx_rdata;
            valid_q[k_q] <= 1'b1;
         end
      end
   end

   // Output flattening.
   always_comb begin
      bus.busy            = (state_q != IDLE);
      bus.done            = (state_q == DONE);
      bus.oam_addr        = addr_q;
      bus.gfx_addr        = (state_q == FETCH_REQ)
                            ? {tile_q[k_q], row_q[k_q]} : 9'd0;
      bus.sprite_valid    = valid_q;
      bus.sprite_overflow = ovf_q;
      bus.sprite_x        = '0;
      bus.sprite_palette  = '0;
      bus.sprite_pattern  = '0;
      for (int k = 0; k < MAX_SPRITES; k++) begin
         bus.sprite_x[10*k +: 10]       = x_q[k];
         bus.sprite_palette[3*k +: 3]   = pal_q[k];
         bus.sprite_pattern[32*k +: 32] = pat_q[k];
      end
   end
endmodule

// File: tb/tb_sprite_line_eval.sv
// Directed and randomized checks of sprite_line_eval against a
// list-based reference model of the scanline sprite selection.
module tb_sprite_line_eval;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sprite_line_eval_if bus ();

   sprite_line_eval dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] oam [64];
   logic [31:0] gfx [512];

   always @(posedge clk) begin
      bus.oam_rdata <= oam[bus.oam_addr];
      bus.gfx_rdata <= gfx[bus.gfx_addr];
   end

   int compared = 0;
   int mismatched = 0;

   logic [7:0]   e_valid;
   logic [79:0]  e_x;
   logic [23:0]  e_pal;
   logic [255:0] e_pat;
   logic         e_ovf;
   int           e_cyc;
   int           gfx_seen;
   int           first_gfx;
   int           cyc;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(int x, int y, int tile, int pal,
                                      int hf, int vf);
      return {2'b00, 1'(vf), 1'(hf), 3'(pal), 6'(tile), 9'(y), 10'(x)};
   endfunction

   // Reference: walk OAM in order, list up to 8 sprites on the line.
   task automatic model(input int line);
      int n;
      int endc;
      n = 0;
      endc = 65;
      e_valid = '0; e_x = '0; e_pal = '0; e_pat = '0; e_ovf = 1'b0;
      for (int j = 0; j < 64; j++) begin
         int y, d, row, tile;
         logic [31:0] w, r;
         logic [3:0] pix [8];
         y = int'(oam[j][18:10]);
         d = line - y;
         if (d >= 0 && d < 8) begin
            if (n == 8) begin
               e_ovf = 1'b1;
               endc = j + 2;
               break;
            end
            tile = int'(oam[j][24:19]);
            row = oam[j][29] ? 7 - d : d;
            w = gfx[tile * 8 + row];
            for (int p = 0; p < 8; p++) pix[p] = w[31 - 4*p -: 4];
            r = '0;
            for (int p = 0; p < 8; p++) begin
               int src;
               src = oam[j][28] ? 7 - p : p;
               r = {r[27:0], pix[src]};
            end
            e_x[10*n +: 10]  = oam[j][9:0];
            e_pal[3*n +: 3]  = oam[j][27:25];
            e_pat[32*n +: 32] = r;
            e_valid[n] = 1'b1;
            n++;
         end
      end
      e_cyc = endc + 1 + 2 * n;
   endtask

   task automatic run(input int line, input int mid_c);
      @(negedge clk);
      bus.start = 1'b1;
      bus.next_line = 9'(line);
      cyc = -1;
      gfx_seen = 0;
      first_gfx = -1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.start = (c + 1 == mid_c);
         if (mid_c > 0) bus.next_line = 9'((line + 3) % 480);
         if (bus.gfx_addr != 9'd0) begin
            gfx_seen++;
            if (first_gfx < 0) first_gfx = int'(bus.gfx_addr);
         end
         if (bus.done) begin
            cyc = c + 1;
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic check_all(input string t);
      chk({t, "_cycle"}, 256'(cyc), 256'(e_cyc));
      @(negedge clk);
      chk({t, "_donepulse"}, 256'(bus.done), 256'(0));
      chk({t, "_busy"}, 256'(bus.busy), 256'(0));
      chk({t, "_valid"}, 256'(bus.sprite_valid), 256'(e_valid));
      chk({t, "_x"}, 256'(bus.sprite_x), 256'(e_x));
      chk({t, "_pal"}, 256'(bus.sprite_palette), 256'(e_pal));
      chk({t, "_pat"}, bus.sprite_pattern, e_pat);
      chk({t, "_ovf"}, 256'(bus.sprite_overflow), 256'(e_ovf));
   endtask

   task automatic clear_oam(input int y);
      for (int j = 0; j < 64; j++) oam[j] = mk(j * 5, y, j, j, 0, 0);
   endtask

   task automatic rand_oam(input int line);
      for (int j = 0; j < 64; j++) begin
         int y;
         if ($urandom_range(0, 3) == 0)
            y = (line + 512 - int'($urandom_range(0, 11))) % 512;
         else
            y = int'($urandom_range(0, 511));
         oam[j] = mk(int'($urandom_range(0, 1023)), y,
                     int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      int ln;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.next_line = '0;
      for (int i = 0; i < 512; i++) gfx[i] = $urandom;
      clear_oam(500);
      repeat (3) @(negedge clk);
      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_done", 256'(bus.done), 256'(0));
      chk("rst_oam_addr", 256'(bus.oam_addr), 256'(0));
      chk("rst_gfx_addr", 256'(bus.gfx_addr), 256'(0));
      chk("rst_valid", 256'(bus.sprite_valid), 256'(0));
      chk("rst_x", 256'(bus.sprite_x), 256'(0));
      chk("rst_pat", bus.sprite_pattern, 256'(0));
      chk("rst_ovf", 256'(bus.sprite_overflow), 256'(0));
      reset = 1'b1;

      model(100);
      run(100, 0);
      chk("none_gfx_reads", 256'(gfx_seen), 256'(0));
      chk("none_cyc66", 256'(cyc), 256'(66));
      check_all("none");

      oam[5] = mk(37, 98, 3, 2, 0, 0);
      gfx[26] = 32'h12345678;
      model(100);
      run(100, 0);
      chk("single_cyc68", 256'(cyc), 256'(68));
      check_all("single");
      chk("single_pat0", 256'(bus.sprite_pattern[31:0]), 256'(32'h12345678));

      oam[5] = mk(37, 98, 3, 2, 1, 1);
      gfx[29] = 32'h12345678;
      model(100);
      run(100, 0);
      chk("flip_gfx_addr", 256'(first_gfx), 256'(29));
      check_all("flip");
      chk("flip_pat0", 256'(bus.sprite_pattern[31:0]), 256'(32'h87654321));

      clear_oam(500);
      for (int j = 0; j < 10; j++) oam[j] = mk(j + 1, 50, j + 1, j % 8, 0, 0);
      model(50);
      run(50, 0);
      check_all("ovf");
      chk("ovf_flag", 256'(bus.sprite_overflow), 256'(1));
      chk("ovf_valid", 256'(bus.sprite_valid), 256'(8'hFF));

      clear_oam(500);
      oam[1] = mk(11, 100, 1, 1, 0, 0);
      oam[2] = mk(22, 93, 2, 2, 0, 0);
      oam[3] = mk(33, 92, 3, 3, 0, 0);
      oam[4] = mk(44, 101, 4, 4, 0, 0);
      model(100);
      run(100, 0);
      check_all("bound");
      chk("bound_valid", 256'(bus.sprite_valid), 256'(8'h03));

      clear_oam(505);
      model(0);
      run(0, 0);
      check_all("top_wrap");
      chk("top_wrap_valid", 256'(bus.sprite_valid), 256'(0));

      ln = int'($urandom_range(0, 479));
      rand_oam(ln);
      model(ln);
      run(ln, 10);
      check_all("mid_start");

      clear_oam(500);
      oam[7] = mk(70, 200, 9, 5, 0, 0);
      oam[9] = mk(90, 198, 10, 6, 0, 0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.next_line = 9'd200;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (66) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 256'(bus.busy), 256'(0));
      chk("midrst_done", 256'(bus.done), 256'(0));
      chk("midrst_oam_addr", 256'(bus.oam_addr), 256'(0));
      chk("midrst_gfx_addr", 256'(bus.gfx_addr), 256'(0));
      chk("midrst_valid", 256'(bus.sprite_valid), 256'(0));
      chk("midrst_x", 256'(bus.sprite_x), 256'(0));
      chk("midrst_pal", 256'(bus.sprite_palette), 256'(0));
      chk("midrst_pat", bus.sprite_pattern, 256'(0));
      reset = 1'b1;
      model(200);
      run(200, 0);
      check_all("after_rst");

      for (int it = 0; it < 6; it++) begin
         ln = int'($urandom_range(0, 479));
         rand_oam(ln);
         for (int i = 0; i < 512; i++) gfx[i] = $urandom;
         model(ln);
         run(ln, 0);
         check_all($sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sprite_line_eval.md
Name: sprite_line_eval

Overview:
- Per-scanline sprite evaluation and pattern fetch stage, directly upstream of the sprite shift register block and priority encoder.
- During the active portion of line L it scans OAM for sprites intersecting line L+1 and keeps up to MAX_SPRITES hits in priority order (lowest OAM index first).
- It then fetches each hit's pattern row from sprite graphics memory and presents per-slot x, palette and pattern data.
- The shift register block loads these outputs at the start of the next line.

Parameters:
- N_OAM, 64, number of OAM entries scanned (power of 2).
- MAX_SPRITES, 8, sprite slots per line.
- SPRITE_H, 8, sprite height in lines (fixed 8 wide, 4 bpp).

Ports:
- clk  in  1  system clock; the single clock for the block.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins evaluation of next_line.
- next_line  in  9  line to evaluate (0..479); sampled on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; slot outputs are valid and stable.
- oam_addr  out  log2(N_OAM)  OAM read address; read latency is 1 cycle.
- oam_rdata  in  32  OAM word: [9:0] x, [18:10] y, [24:19] tile, [27:25] palette, [28] hflip, [29] vflip, [31:30] ignored.
- gfx_addr  out  9  sprite graphics read address {tile[5:0], row[2:0]}; read latency is 1 cycle.
- gfx_rdata  in  32  8 pixels × 4 bits; [31:28] is the leftmost pixel.
- sprite_valid  out  MAX_SPRITES  per-slot valid.
- sprite_x  out  MAX_SPRITES*10  per-slot x; slot k occupies [10k+9:10k].
- sprite_palette  out  MAX_SPRITES*3  per-slot palette.
- sprite_pattern  out  MAX_SPRITES*32  per-slot row pattern, with hflip already applied.
- sprite_overflow  out  1  more than MAX_SPRITES sprites were found on the evaluated line.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state returns to IDLE from any state, including mid-scan or mid-fetch.
  - busy=0, done=0, oam_addr=0, gfx_addr=0.
  - All sprite_valid bits clear; sprite_x, sprite_palette, sprite_pattern = 0; sprite_overflow=0.
- States: IDLE → SCAN → FETCH_REQ ⇄ FETCH_WAIT → DONE → IDLE.
- Cycle numbering: cycle 0 is the edge at which start=1 is sampled in IDLE.
- Start (cycle 0):
  - latch next_line.
  - clear sprite_valid, hit count and sprite_overflow.
  - oam_addr<=0; go to SCAN.
- start while not in IDLE is ignored.
- SCAN, address issue:
  - oam_addr increments by 1 every cycle, holding value j during cycle j+1.
  - The last address N_OAM-1 is held once issued.
- SCAN, evaluation of entry j (in cycle j+2, using a pipeline-valid flag):
  - diff = {1'b0,line} - {1'b0,y}, 10 bits.
  - Hit when diff[9]=0 and diff < SPRITE_H.
  - On a hit, write slot[count]: x, palette, tile, hflip, and row = vflip ? SPRITE_H-1-diff[2:0] : diff[2:0]. Then count+1.
- Overflow: a hit while count==MAX_SPRITES sets sprite_overflow=1, discards that entry, and ends SCAN at once. Any in-flight OAM read is discarded.
- Normal end: SCAN ends after entry N_OAM-1 is evaluated (cycle N_OAM+1).
- FETCH, per slot k = 0..count-1, two cycles per slot:
  - FETCH_REQ drives gfx_addr={tile_k,row_k}.
  - FETCH_WAIT captures gfx_rdata into sprite_pattern[k]. If hflip, nibble order is reversed (pixel i ↔ pixel 7-i). sprite_valid[k]<=1 in the same cycle.
  - count==0 skips fetch entirely.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency without overflow: done is high in cycle N_OAM+2+2·count.
- Between done and the next start, all slot outputs hold their values.
- Unused slots: sprite_valid=0; x, palette and pattern = 0.
- Lines near the top edge: y > line gives diff[9]=1, so no hit; unsigned wrap must never produce a hit. y up to 511 is accepted, with no clamping.

Test Plan:
- No sprites on line:
  - All OAM y=500, start with next_line=100.
  - Expect done in cycle 66, sprite_valid=0, overflow=0, 0 gfx reads.
- Single sprite:
  - Entry 5 = {x=37, y=98, tile=3, pal=2}, gfx[{3,2}]=0x12345678, start with next_line=100.
  - Expect slot0 x=37, pal=2, pattern=0x12345678, valid=8'h01.
  - Expect done in cycle 68.
- Flips:
  - Same entry with hflip=1, vflip=1.
  - Expect gfx_addr={3,5} and pattern=0x87654321.
- Overflow:
  - Entries 0..9 all hit line 50 (y=50).
  - Expect slots 0..7 = entries 0..7, overflow=1, valid=8'hFF.
  - Expect entries 8 and 9 absent.
- Boundaries:
  - y=100 and y=93 hit line 100.
  - y=92 and y=101 do not.
  - line=0 with y=505 does not hit.
- Mid-operation events:
  - start asserted during SCAN is ignored; the result is unchanged.
  - reset=0 during FETCH gives IDLE next cycle with all outputs zero.
  - A subsequent start then completes normally.
